// File: rtl/display_scan.sv
// rtl/display_scan.sv - four-digit multiplexed display scanner with anti-ghost blanking
// Optional leading-zero blanking: define DISPLAY_SCAN_LZB_EN.
module display_scan #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  ext_mask,
    output logic [3:0]  num,
    output logic        EXTENDED,
    output logic [3:0]  an,
    output logic [1:0]  idx
);

    localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    num_q, num_d;
    logic          ext_q, ext_d;
    logic [15:0]   shadow_data_q, shadow_data_d;
    logic [3:0]    shadow_mask_q, shadow_mask_d;

    logic [3:0]    dig_num;
    logic          dig_ext;

    // Digit values come from the pre-load shadow so a coincident load lands on the next digit.
    always_comb begin
        dig_num = shadow_data_q[{idx_q, 2'b00} +: 4];
        dig_ext = shadow_mask_q[idx_q];
`ifdef DISPLAY_SCAN_LZB_EN
        if ((idx_q != 2'd0) && ((shadow_data_q >> {idx_q, 2'b00}) == 16'h0)) begin
            dig_num = 4'h0;
            dig_ext = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        an_d          = an_q;
        num_d         = num_q;
        ext_d         = ext_q;
        shadow_data_d = load ? data : shadow_data_q;
        shadow_mask_d = load ? ext_mask : shadow_mask_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                an_d  = 4'b1111;
                if (en) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHOW;
                    an_d    = ~(4'b0001 << idx_q);
                    num_d   = dig_num;
                    ext_d   = dig_ext;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = S_BLANK;
                    idx_d   = idx_q + 2'd1;
                    an_d    = 4'b1111;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                an_d    = 4'b1111;
            end
        endcase

        // Disable wins over everything; decoder inputs are left as they were.
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
            an_d    = 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            an_q          <= 4'b1111;
            num_q         <= 4'h0;
            ext_q         <= 1'b0;
            shadow_data_q <= 16'h0;
            shadow_mask_q <= 4'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            num_q         <= num_d;
            ext_q         <= ext_d;
            shadow_data_q <= shadow_data_d;
            shadow_mask_q <= shadow_mask_d;
        end
    end

    assign num      = num_q;
    assign EXTENDED = ext_q;
    assign an       = an_q;
    assign idx      = idx_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - self-checking bench for display_scan (DIV=8, BLANK=2)
module tb_display_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int PER   = DIV + BLANK;
`ifdef DISPLAY_SCAN_LZB_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  ext_mask = 4'h0;
    logic [3:0]  num;
    logic        EXTENDED;
    logic [3:0]  an;
    logic [1:0]  idx;

    int checks = 0;
    int errors = 0;

    display_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data),
        .ext_mask(ext_mask), .num(num), .EXTENDED(EXTENDED), .an(an), .idx(idx)
    );

    always #5 clk = ~clk;

    // Reference: position within the scan measured in edges since leaving idle.
    bit          m_run;
    int          m_k;
    logic [3:0]  m_an, m_num;
    logic        m_ext;
    logic [1:0]  m_idx;
    logic [15:0] m_shadow;
    logic [3:0]  m_mask;

    task automatic model_reset();
        m_run = 0; m_k = 0; m_an = 4'hF; m_num = 4'h0; m_ext = 1'b0;
        m_idx = 2'd0; m_shadow = 16'h0; m_mask = 4'h0;
    endtask

    task automatic model_edge();
        int pos, ph, dg;
        if (!en) begin
            m_run = 0; m_k = 0; m_an = 4'hF; m_idx = 2'd0;
        end else begin
            if (!m_run) begin
                m_run = 1; m_k = 1;
            end else begin
                m_k++;
            end
            pos   = m_k - 1;
            ph    = pos % PER;
            dg    = (pos / PER) % 4;
            m_idx = 2'(dg);
            m_an  = (ph < BLANK) ? 4'hF : ~(4'(1) << dg);
            if (ph == BLANK) begin
                m_num = 4'((m_shadow >> (4 * dg)) & 16'hF);
                m_ext = m_mask[dg];
                if (LZ && dg > 0 && (m_shadow >> (4 * dg)) == 16'h0) begin
                    m_num = 4'h0;
                    m_ext = 1'b1;
                end
            end
        end
        if (load) begin
            m_shadow = data;
            m_mask   = ext_mask;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model", {5'b0, an, num, EXTENDED, idx}, {5'b0, m_an, m_num, m_ext, m_idx});
    endtask

    typedef struct packed {
        logic [7:0]  n;
        logic        en;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  m;
        logic [3:0]  an;
        logic [3:0]  num;
        logic        ext;
        logic [1:0]  idx;
    } vec_t;

    vec_t vecs[21];

    initial begin
        vecs = '{
            '{8'd2,  1'b1, 1'b0, 16'h0,    4'h0, 4'hF, 4'h0, 1'b0, 2'd0},
            '{8'd1,  1'b1, 1'b0, 16'h0,    4'h0, 4'hE, 4'h0, 1'b0, 2'd0},
            '{8'd7,  1'b1, 1'b0, 16'h0,    4'h0, 4'hE, 4'h0, 1'b0, 2'd0},
            '{8'd1,  1'b1, 1'b0, 16'h0,    4'h0, 4'hF, 4'h0, 1'b0, 2'd1},
            '{8'd2,  1'b1, 1'b0, 16'h0,    4'h0, 4'hD, 4'h0, LZ,   2'd1},
            '{8'd1,  1'b1, 1'b1, 16'h4321, 4'h0, 4'hD, 4'h0, LZ,   2'd1},
            '{8'd7,  1'b1, 1'b0, 16'h0,    4'h0, 4'hF, 4'h0, LZ,   2'd2},
            '{8'd2,  1'b1, 1'b0, 16'h0,    4'h0, 4'hB, 4'h3, 1'b0, 2'd2},
            '{8'd10, 1'b1, 1'b0, 16'h0,    4'h0, 4'h7, 4'h4, 1'b0, 2'd3},
            '{8'd10, 1'b1, 1'b0, 16'h0,    4'h0, 4'hE, 4'h1, 1'b0, 2'd0},
            '{8'd10, 1'b1, 1'b0, 16'h0,    4'h0, 4'hD, 4'h2, 1'b0, 2'd1},
            '{8'd1,  1'b1, 1'b1, 16'hABCD, 4'h4, 4'hD, 4'h2, 1'b0, 2'd1},
            '{8'd9,  1'b1, 1'b0, 16'h0,    4'h0, 4'hB, 4'hB, 1'b1, 2'd2},
            '{8'd1,  1'b0, 1'b0, 16'h0,    4'h0, 4'hF, 4'hB, 1'b1, 2'd0},
            '{8'd3,  1'b0, 1'b0, 16'h0,    4'h0, 4'hF, 4'hB, 1'b1, 2'd0},
            '{8'd2,  1'b1, 1'b0, 16'h0,    4'h0, 4'hF, 4'hB, 1'b1, 2'd0},
            '{8'd1,  1'b1, 1'b0, 16'h0,    4'h0, 4'hE, 4'hD, 1'b0, 2'd0},
            '{8'd8,  1'b1, 1'b0, 16'h0,    4'h0, 4'hF, 4'hD, 1'b0, 2'd1},
            '{8'd1,  1'b1, 1'b0, 16'h0,    4'h0, 4'hF, 4'hD, 1'b0, 2'd1},
            '{8'd1,  1'b1, 1'b1, 16'h1234, 4'hF, 4'hD, 4'hC, 1'b0, 2'd1},
            '{8'd10, 1'b1, 1'b0, 16'h0,    4'h0, 4'hB, 4'h2, 1'b1, 2'd2}
        };

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_an",  {12'b0, an},       16'hF);
        chk("reset_num", {12'b0, num},      16'h0);
        chk("reset_ext", {15'b0, EXTENDED}, 16'h0);
        chk("reset_idx", {14'b0, idx},      16'h0);

        en = 1'b1;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            en = vecs[i].en;
            load = vecs[i].ld;
            data = vecs[i].d;
            ext_mask = vecs[i].m;
            tick();
            load = 1'b0;
            for (int c = 1; c < int'(vecs[i].n); c++) tick();
            chk($sformatf("vec%0d_an", i),  {12'b0, an},       {12'b0, vecs[i].an});
            chk($sformatf("vec%0d_num", i), {12'b0, num},      {12'b0, vecs[i].num});
            chk($sformatf("vec%0d_ext", i), {15'b0, EXTENDED}, {15'b0, vecs[i].ext});
            chk($sformatf("vec%0d_idx", i), {14'b0, idx},      {14'b0, vecs[i].idx});
        end

        for (int i = 0; i < 600; i++) begin
            int mode;
            en = ($urandom_range(0, 39) != 0);
            load = ($urandom_range(0, 5) == 0);
            mode = $urandom_range(0, 3);
            data = (mode == 0) ? 16'($urandom_range(0, 15)) :
                   (mode == 1) ? 16'h0 : 16'($urandom);
            ext_mask = 4'($urandom);
            tick();
        end

        // Asynchronous reset in the middle of a digit.
        en = 1'b1;
        load = 1'b0;
        begin
            int guard = 0;
            tick();
            while (m_an == 4'hF && guard < 40) begin
                tick();
                guard++;
            end
            chk("reach_show", {15'b0, (m_an != 4'hF)}, 16'h1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_an",  {12'b0, an},       16'hF);
        chk("async_idx", {14'b0, idx},      16'h0);
        chk("async_num", {12'b0, num},      16'h0);
        chk("async_ext", {15'b0, EXTENDED}, 16'h0);
        model_reset();
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("rst_blank_an", {12'b0, an}, 16'hF);
        tick();
        chk("rst_show_an",  {12'b0, an},  16'hE);
        chk("rst_show_idx", {14'b0, idx}, 16'h0);
        chk("rst_show_num", {12'b0, num}, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The module SHALL have parameter DIV, default 50000, giving the SHOW-phase length in clock cycles per digit (DIV >= 2).
REQ-002 The module SHALL have parameter BLANK, default 500, giving the anti-ghost blanking length in clock cycles before each digit (BLANK >= 1).
REQ-003 The module SHALL have port clk, input, width 1, the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_n, input, width 1, the asynchronous active-low reset.
REQ-005 The module SHALL have port en, input, width 1, enabling scanning.
REQ-006 The module SHALL have port load, input, width 1, a strobe that captures data and ext_mask.
REQ-007 The module SHALL have port data, input, width 16, carrying four hex digits (digit i = data[4i+3:4i]).
REQ-008 The module SHALL have port ext_mask, input, width 4, the per-digit EXTENDED flag.
REQ-009 The module SHALL have port num, output, width 4, the nibble feeding the 7-segment decoder.
REQ-010 The module SHALL have port EXTENDED, output, width 1, the mode flag feeding the decoder.
REQ-011 The module SHALL have port an, output, width 4, the active-low digit anodes.
REQ-012 The module SHALL have port idx, output, width 2, the index of the current digit.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have exactly three states, IDLE, BLANK and SHOW, plus one shared phase counter.
REQ-015 IDLE: an=4'b1111 and the phase counter SHALL be 0; with en=1 the FSM SHALL go to BLANK on the next edge.
REQ-016 BLANK: an=4'b1111 for exactly BLANK cycles, then SHOW; on that transition num, EXTENDED and an SHALL update from the shadow registers for digit idx.
REQ-017 SHOW: an has only bit idx low, held for exactly DIV cycles; then idx SHALL advance by 1 (3 wraps to 0) and the FSM SHALL enter BLANK.
REQ-018 One full scan period SHALL be 4*(BLANK+DIV) cycles.
REQ-019 load=1 SHALL copy data and ext_mask into the shadow registers on that edge, in any state.
REQ-020 num and EXTENDED SHALL change only on BLANK->SHOW transitions, never mid-digit.
REQ-021 When load coincides with a BLANK->SHOW transition, the transition SHALL use the old shadow value; the new value appears from the next digit.
REQ-022 en=0 in any state SHALL force IDLE on the next edge, with an=4'b1111 and idx=0; num and EXTENDED SHALL hold their values.
REQ-023 In BLANK the decoder inputs SHALL hold the previous digit's values, which are harmless because all anodes are off.

Reset
REQ-024 When rst_n=0, asynchronously: state=IDLE, counter=0, idx=0, an=4'b1111, num=4'h0, EXTENDED=0, and shadow data and mask = 0.
REQ-025 Reset deassertion during a scan SHALL restart the scan from digit 0 after a full BLANK phase.

Configuration
REQ-026 Macro DISPLAY_SCAN_LZB_EN SHALL enable leading-zero blanking.
REQ-027 With DISPLAY_SCAN_LZB_EN defined, any digit i>0 whose nibble and all higher nibbles are 0 SHALL be output as num=4'h0 with EXTENDED=1, which the decoder renders blank. Digit 0 SHALL always be shown normally.
REQ-028 With DISPLAY_SCAN_LZB_EN undefined, all digits SHALL be output as stored, with EXTENDED=ext_mask[idx].

Verification (DIV=8, BLANK=2)
REQ-029 Reset with en=1, no load -> an=1111 for 2 cycles, then an=1110 for 8 cycles with num=0 and idx=0, then 2 blank cycles, then an=1101.
REQ-030 load data=16'h4321, ext_mask=0 -> over one 40-cycle scan, num=1,2,3,4 with an=1110,1101,1011,0111; after digit 3, idx wraps to 0.
REQ-031 Load 16'hABCD during a SHOW of digit 1 -> num stays at the old value until that SHOW ends; digit 2 shows 4'hB.
REQ-032 Deassert en mid-SHOW -> an=1111 and idx=0 on the next edge; re-enable -> 2 blank cycles, then digit 0.
REQ-033 With DISPLAY_SCAN_LZB_EN, data=16'h0005 -> digits 1-3 give num=0, EXTENDED=1; digit 0 gives num=5, EXTENDED=0. data=16'h0000 -> digit 0 shows num=0, EXTENDED=0.
REQ-034 Assert rst_n=0 asynchronously mid-SHOW, between clock edges -> an=1111 immediately, with no clock edge required.
